// File: rtl/instr_loader_pkg.sv
// Shared constants for the instruction loader: RV32I opcodes, request kind
// and ALU select codes, funct fields, and the loader FSM state type.
package instr_loader_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] KIND_LW  = 2'b00;
    localparam logic [1:0] KIND_SW  = 2'b01;
    localparam logic [1:0] KIND_R   = 2'b10;
    localparam logic [1:0] KIND_BEQ = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Request and instruction-memory write bundle between a source (master)
// and the loader (slave).
interface instr_loader_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [31:0]      base_addr;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       kind;
    logic [2:0]       alu_sel;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [12:0]      imm;
    logic             last;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             err;
    logic             done;
    logic [CNT_W-1:0] count;

    modport master (
        output start, base_addr, in_valid, kind, alu_sel, rd, rs1, rs2, imm, last,
        input  in_ready, mem_we, mem_addr, mem_wdata, err, done, count
    );

    modport slave (
        input  start, base_addr, in_valid, kind, alu_sel, rd, rs1, rs2, imm, last,
        output in_ready, mem_we, mem_addr, mem_wdata, err, done, count
    );
endinterface

// File: rtl/instr_loader_encode.sv
// Combinational RV32I field packer for lw/sw/R-type/beq requests; flags
// requests that have no legal encoding.
module rv_instr_encode
    import instr_loader_pkg::*;
(
    input  logic [1:0]  i_kind,
    input  logic [2:0]  i_alu_sel,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [12:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        o_word    = '0;
        o_illegal = 1'b0;
        w_funct3  = F3_ADD_SUB;
        w_funct7  = (i_alu_sel == ALU_SUB) ? F7_SUB : F7_BASE;

        unique case (i_alu_sel)
            ALU_ADD, ALU_SUB: w_funct3 = F3_ADD_SUB;
            ALU_AND:          w_funct3 = F3_AND;
            ALU_OR:           w_funct3 = F3_OR;
            ALU_SLT:          w_funct3 = F3_SLT;
            default:          w_funct3 = F3_ADD_SUB;
        endcase

        unique case (i_kind)
            KIND_LW: o_word = {i_imm[11:0], i_rs1, F3_WORD, i_rd, OP_LOAD};
            KIND_SW: o_word = {i_imm[11:5], i_rs2, i_rs1, F3_WORD, i_imm[4:0], OP_STORE};
            KIND_R: begin
                o_word    = {w_funct7, i_rs2, i_rs1, w_funct3, i_rd, OP_OP};
                o_illegal = (i_alu_sel > ALU_SLT);
            end
            default: begin
                o_word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                             i_imm[4:1], i_imm[11], OP_BRANCH};
                // Branch offsets are halfword multiples; an odd offset is unencodable.
                o_illegal = i_imm[0];
            end
        endcase
    end
endmodule

// File: rtl/instr_loader.sv
// Streams encoded RV32I words into instruction memory from a base address,
// one request per cycle, with registered write outputs and session control.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_loader_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           r_state;
    state_e           w_next;
    logic [31:0]      r_addr;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_mem_we;
    logic             r_err;
    logic [CNT_W-1:0] r_count;

    logic [31:0]      w_word;
    logic             w_illegal;
    logic             w_accept;
    logic             w_write;
    logic             w_reject;
    logic             w_ready;
    logic             w_done;

    rv_instr_encode u_encode (
        .i_kind    (bus.kind),
        .i_alu_sel (bus.alu_sel),
        .i_rd      (bus.rd),
        .i_rs1     (bus.rs1),
        .i_rs2     (bus.rs2),
        .i_imm     (bus.imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_accept = w_ready && bus.in_valid;
    assign w_write  = w_accept && !w_illegal;
    assign w_reject = w_accept && w_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses <= so all flops update from pre-edge values.
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_RUN;
            ST_RUN: begin
                w_ready = 1'b1;
                if (w_accept && bus.last) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= RESET_ADDR;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_err       <= 1'b0;
            r_mem_addr  <= RESET_ADDR;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_write;
            r_err    <= w_reject;
            if (r_state == ST_IDLE && bus.start) begin
                r_addr  <= bus.base_addr;
                r_count <= '0;
            end
            // Rejected requests leave address, count and the write bus untouched.
            if (w_write) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= w_word;
                r_addr      <= r_addr + 32'd4;
                if (r_count != '1) r_count <= r_count + CNT_ONE;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.done      = w_done;
    assign bus.mem_we    = r_mem_we;
    assign bus.err       = r_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: each accepted request queues its expected
// output, which the monitor pops when the DUT writes or rejects.
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int          CW    = 3;
    localparam logic [31:0] RST_A = 32'h0000_2000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_loader_if #(.CNT_W(CW)) ifc ();

    instr_loader #(.RESET_ADDR(RST_A), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    typedef struct {
        logic          err;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [CW-1:0] cnt;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [31:0]   m_addr = '0;
    logic [CW-1:0] m_cnt  = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // {illegal, word} from the RV32I field layouts.
    function automatic logic [32:0] model_enc(input logic [1:0] k, input logic [2:0] a,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [12:0] imm);
        logic [2:0] f3;
        logic [6:0] f7;
        case (k)
            2'b00: return {1'b0, imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            2'b01: return {1'b0, imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            2'b10: begin
                f7 = (a == 3'd1) ? 7'b0100000 : 7'b0000000;
                case (a)
                    3'd0, 3'd1: f3 = 3'b000;
                    3'd2:       f3 = 3'b111;
                    3'd3:       f3 = 3'b110;
                    3'd4:       f3 = 3'b010;
                    default:    return {1'b1, 32'h0};
                endcase
                return {1'b0, f7, rs2, rs1, f3, rd, 7'b0110011};
            end
            default: begin
                if (imm[0]) return {1'b1, 32'h0};
                return {1'b0, imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.mem_we || ifc.err) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("err", ifc.err, mon_e.err);
                    check("mem_we", ifc.mem_we, !mon_e.err);
                    if (!mon_e.err) begin
                        check("mem_addr", ifc.mem_addr, mon_e.addr);
                        check("mem_wdata", ifc.mem_wdata, mon_e.data);
                    end
                    check("count", ifc.count, mon_e.cnt);
                    check("done", ifc.done, mon_e.last);
                end
            end else if (ifc.done) begin
                check("stray_done", 32'd1, 32'd0);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, ifc.in_ready, 32'd0);
        check({tag, "_mem_we"}, ifc.mem_we, 32'd0);
        check({tag, "_err"}, ifc.err, 32'd0);
        check({tag, "_done"}, ifc.done, 32'd0);
        check({tag, "_mem_addr"}, ifc.mem_addr, RST_A);
        check({tag, "_mem_wdata"}, ifc.mem_wdata, 32'd0);
        check({tag, "_count"}, ifc.count, 32'd0);
    endtask

    // Entered and left just after a rising edge.
    task automatic do_start(input logic [31:0] base);
        ifc.start     = 1'b1;
        ifc.base_addr = base;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        m_addr    = base;
        m_cnt     = '0;
        @(negedge clk);
        check("start_count", ifc.count, 32'd0);
        check("start_ready", ifc.in_ready, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [1:0] k, input logic [2:0] a, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                        input logic last, input logic exp_err, input logic [31:0] exp_data);
        exp_t e;
        int   n;
        ifc.kind = k; ifc.alu_sel = a; ifc.rd = rd; ifc.rs1 = rs1; ifc.rs2 = rs2;
        ifc.imm = imm; ifc.last = last; ifc.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ifc.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.in_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            ifc.in_valid = 1'b0;
            return;
        end
        e.err  = exp_err;
        e.data = exp_data;
        e.last = last;
        e.addr = m_addr;
        if (!exp_err) begin
            m_addr = m_addr + 32'd4;
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [1:0] k, input logic [2:0] a, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                          input logic last);
        logic [32:0] r;
        r = model_enc(k, a, rd, rs1, rs2, imm);
        send(k, a, rd, rs1, rs2, imm, last, r[32], r[31:0]);
    endtask

    task automatic end_session(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_drained"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.start = 0; ifc.base_addr = '0; ifc.in_valid = 0; ifc.kind = '0; ifc.alu_sel = '0;
        ifc.rd = '0; ifc.rs1 = '0; ifc.rs2 = '0; ifc.imm = '0; ifc.last = 0;
        #12;
        check_reset_vals("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single lw
        do_start(32'h0000_0100);
        send(KIND_LW, 3'd0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b1, 1'b0, 32'h0081_2283);
        end_session("lw");

        // Back-to-back sw, sub, beq -8
        do_start(32'h0000_0000);
        send(KIND_SW, 3'd0, 5'd0, 5'd2, 5'd6, 13'd12, 1'b0, 1'b0, 32'h0061_2623);
        send(KIND_R, ALU_SUB, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0, 1'b0, 32'h4031_00B3);
        send(KIND_BEQ, 3'd0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 1'b1, 1'b0, 32'hFE20_8CE3);
        end_session("stream");

        // Illegal alu_sel then add at the base address
        do_start(32'h0000_0040);
        send(KIND_R, 3'b111, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0, 1'b1, 32'h0);
        send(KIND_R, ALU_ADD, 5'd1, 5'd1, 5'd1, 13'd0, 1'b1, 1'b0, 32'h0010_80B3);
        end_session("err");

        // Address wrap
        do_start(32'hFFFF_FFFC);
        send_m(KIND_LW, 3'd0, 5'd3, 5'd4, 5'd0, 13'h0FF0, 1'b0);
        send_m(KIND_LW, 3'd0, 5'd7, 5'd8, 5'd0, 13'h0004, 1'b1);
        end_session("wrap");

        // start during RUN ignored; odd beq offset rejected as last request
        do_start(32'h0000_0300);
        ifc.start = 1'b1; ifc.base_addr = 32'h0000_0900;
        send_m(KIND_R, ALU_OR, 5'd9, 5'd10, 5'd11, 13'd0, 1'b0);
        send_m(KIND_R, ALU_SLT, 5'd12, 5'd13, 5'd14, 13'd0, 1'b0);
        ifc.start = 1'b0;
        send(KIND_BEQ, 3'd0, 5'd0, 5'd1, 5'd2, 13'h0011, 1'b1, 1'b1, 32'h0);
        end_session("beq_odd");
        repeat (4) @(posedge clk);
        #1;
        check("idle_count_hold", ifc.count, m_cnt);

        // Count saturation at all-ones
        do_start(32'h0000_1000);
        for (int i = 0; i < 9; i++)
            send_m(KIND_LW, 3'd0, 5'(i), 5'd1, 5'd0, 13'(4 * i), (i == 8));
        end_session("sat");

        // Random session with gaps
        do_start({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            send_m(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom),
                   5'($urandom), 5'($urandom), 13'($urandom), (i == 15));
        end
        end_session("rand");

        // Reset in the cycle after acceptance drops the pending write
        do_start(32'h0000_0500);
        send_m(KIND_LW, 3'd0, 5'd1, 5'd2, 5'd0, 13'd4, 1'b0);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifc.kind = KIND_LW; ifc.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready", ifc.in_ready, 32'd0);
            check("idle_we", ifc.mem_we, 32'd0);
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        do_start(32'h0000_0600);
        send_m(KIND_SW, 3'd0, 5'd0, 5'd3, 5'd4, 13'h0ABC, 1'b1);
        end_session("recover");

        check("final_sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL provide parameters: RESET_ADDR, default 32'h0000_0000, power-up base address; CNT_W, default 16, word-counter width.
REQ-002 SHALL have one clock and asynchronous active-low reset: clk, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  pulse, begins a load session at base_addr.
REQ-006 base_addr  input  32  first instruction-memory byte address of the session.
REQ-007 in_valid  input  1  source has an instruction request.
REQ-008 in_ready  output  1  loader accepts a request this cycle.
REQ-009 kind  input  2  00 lw, 01 sw, 10 R-type, 11 beq.
REQ-010 alu_sel  input  3  R-type op: 000 add, 001 sub, 010 and, 011 or, 100 slt; others illegal.
REQ-011 rd, rs1, rs2  input  5 each  register indices.
REQ-012 imm  input  13  lw/sw use imm[11:0]; beq uses a signed byte offset imm[12:0].
REQ-013 last  input  1  final request of the session.
REQ-014 mem_we  output  1  instruction-memory write strobe.
REQ-015 mem_addr  output  32  write byte address.
REQ-016 mem_wdata  output  32  encoded RV32I word.
REQ-017 err  output  1  one-cycle pulse, request rejected.
REQ-018 done  output  1  one-cycle pulse, session finished.
REQ-019 count  output  CNT_W  words written in the current or most recent session.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-021 IDLE: in_ready=0; on start, latch base_addr into the address register, clear count and go to RUN.
REQ-022 RUN: in_ready=1; a request is accepted when in_valid&&in_ready; start is ignored.
REQ-023 Throughput SHALL be one request per cycle.
REQ-024 mem_we, mem_addr and mem_wdata SHALL be registered and valid exactly one cycle after acceptance; mem_we SHALL otherwise be 0.
REQ-025 Encodings are as follows.
  - lw: {imm[11:0],rs1,3'b010,rd,7'b0000011}
  - sw: {imm[11:5],rs2,rs1,3'b010,imm[4:0],7'b0100011}
  - R-type: {funct7,rs2,rs1,funct3,rd,7'b0110011}, where funct3 is add/sub 000, and 111, or 110, slt 010, and funct7 is 0100000 for sub and 0000000 otherwise.
  - beq: {imm[12],imm[10:5],rs2,rs1,3'b000,imm[4:1],imm[11],7'b1100011}.
REQ-026 Error cases are an illegal alu_sel for R-type and beq with imm[0]=1.
  - In either case err SHALL pulse in the output cycle, with mem_we=0 and the address and count unchanged.
REQ-027 Each successful write SHALL advance the address by 4 (modulo 2^32, wrap 32'hFFFF_FFFC -> 0) and increment count (saturating at all-ones).
REQ-028 An accepted request with last=1 SHALL move the FSM to DONE, whether or not that request errors.
REQ-029 DONE: in_ready=0; done=1 for exactly this one cycle; the next state is IDLE.
REQ-030 The last write and done SHALL appear in the same cycle.
REQ-031 count SHALL hold its value in IDLE until the next start.

Reset
REQ-032 While rst_n=0, the outputs SHALL be as follows.
  - State is IDLE; the address register holds RESET_ADDR.
  - in_ready, mem_we, err and done are 0.
  - mem_addr is RESET_ADDR, mem_wdata is 0 and count is 0.
REQ-033 Reset mid-session SHALL abort the session immediately with no further writes; a pending output-stage write SHALL be dropped.

Structure
REQ-034 The shared package SHALL hold the opcode constants (7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011), the kind codes, the alu_sel codes, the funct3/funct7 constants and the FSM state typedef.
REQ-035 Field packing SHALL be a combinational sub-module rv_instr_encode (kind, alu_sel, rd, rs1, rs2, imm -> word, illegal).
  - instr_loader holds the FSM, the counters and the output registers.

Verification
REQ-036 Single lw: start with base_addr=0x100; lw rd=5, rs1=2, imm=8, last=1.
  - Next cycle: mem_we=1, mem_addr=0x100, mem_wdata=0x00812283, done=1, count=1.
REQ-037 Back-to-back stream from base 0x0, sw(rs2=6, rs1=2, imm=12), sub(rd=1, rs1=2, rs2=3), beq(rs1=1, rs2=2, imm=-8, last=1), in consecutive cycles:
  - Writes 0x00612623@0x0, 0x403100B3@0x4, 0xFE208CE3@0x8.
  - done pulses with the third write; count=3.
REQ-038 Error path: R-type with alu_sel=111, then add(rd=1, rs1=1, rs2=1):
  - The first request gives err=1, mem_we=0.
  - The add is written as 0x001080B3 at the base address; count=1.
REQ-039 Wrap: base_addr=0xFFFF_FFFC, two lw requests.
  - Writes at 0xFFFF_FFFC then 0x0000_0000.
REQ-040 Reset mid-session: assert rst_n=0 in the cycle after a request is accepted.
  - No mem_we; all outputs take their reset values; in_ready=0 until a new start.
REQ-041 start asserted during RUN SHALL be ignored; in_valid in IDLE SHALL be ignored, with no writes.
